mem_port_arbiter: RTL and testbench

//  Shares one single-port memory bus between the IF stage (instruction fetch, read-only)
//  and the MEM stage (load/store) of the 5-stage MIPS pipeline.

---
 rtl/mem_port_arbiter_pkg.sv | 37 +++
 rtl/mem_port_arbiter_bus_watchdog.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the IF/MEM memory-port arbiter: arbiter state
// encoding, default bus widths and timing parameters, and small helpers used
// by the arbitration logic.
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    // Default widths and timing
    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned TIMEOUT_DEF = 255;
    localparam int unsigned D_BURST_DEF = 2;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_DATA = 2'd1,
        ARB_INST = 2'd2,
        ARB_RESP = 2'd3
    } arb_state_e;

    // Fetch wins only when data is idle or the data burst limit is reached
    function automatic logic arb_pick_inst(
        input logic ic_req,
        input logic dc_req,
        input logic burst_full
    );
        return ic_req && (!dc_req || burst_full);
    endfunction

    // A bus transaction is in flight in DATA and INST
    function automatic logic arb_busy(input arb_state_e state);
        return (state == ARB_DATA) || (state == ARB_INST);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_bus_watchdog.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_bus_watchdog
// Counts bus cycles spent waiting for bus_ack and flags expiry on the cycle
// the count reaches TIMEOUT.
// Ports:
//   clk         main clock, rising edge
//   rst         asynchronous active-high reset
//   i_clear     clear the count (no transaction in flight)
//   i_enable    count this cycle (transaction in flight, no bus_ack)
//   o_expire_c  combinational: this counted cycle is the TIMEOUT-th one
// -----------------------------------------------------------------------------
module mem_port_arbiter_bus_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_count;

    // Wait-cycle counter; never runs past TIMEOUT because expiry ends the transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // r_count holds the cycles already waited, so this cycle is number r_count+1
    assign o_expire_c = i_enable && (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory bus between the IF stage (read-only fetch)
// and the MEM stage (load/store). One transaction at a time; completion is a
// one-cycle ack pulse with data. A watchdog turns a hung bus transaction into
// an error response with zero data and a sticky bus_err.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   ic_req/ic_addr                fetch request (level, held until ic_ack)
//   ic_data/ic_ack                fetch data and one-cycle completion pulse
//   dc_req/dc_we/dc_addr/dc_wdata data request (level, held until dc_ack)
//   dc_rdata/dc_ack               load data and one-cycle completion pulse
//   bus_cyc/bus_we/bus_addr/bus_wdata  memory bus request
//   bus_rdata/bus_ack             memory bus response
//   stall                         combinational: a request is still pending
//   bus_err                       sticky watchdog error, cleared only by rst
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned D_BURST = D_BURST_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic [DATA_W-1:0] ic_data,
    output logic              ic_ack,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_ack,
    output logic              bus_cyc,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              stall,
    output logic              bus_err
);

    localparam int unsigned BURST_W = (D_BURST < 1) ? 1 : $clog2(D_BURST + 1);

    // State and registered outputs
    arb_state_e          r_state;
    logic [BURST_W-1:0]  r_burst;
    logic                r_bus_cyc;
    logic                r_bus_we;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic [DATA_W-1:0]   r_bus_wdata;
    logic                r_ic_ack;
    logic                r_dc_ack;
    logic [DATA_W-1:0]   r_ic_data;
    logic [DATA_W-1:0]   r_dc_rdata;
    logic                r_bus_err;

    // Next-state values
    arb_state_e          w_state_nxt;
    logic [BURST_W-1:0]  w_burst_nxt;
    logic                w_bus_cyc_nxt;
    logic                w_bus_we_nxt;
    logic [ADDR_W-1:0]   w_bus_addr_nxt;
    logic [DATA_W-1:0]   w_bus_wdata_nxt;
    logic                w_ic_ack_nxt;
    logic                w_dc_ack_nxt;
    logic [DATA_W-1:0]   w_ic_data_nxt;
    logic [DATA_W-1:0]   w_dc_rdata_nxt;
    logic                w_bus_err_nxt;

    logic                w_busy;
    logic                w_burst_full;
    logic                w_pick_inst;
    logic                w_wd_expire_c;
    logic [DATA_W-1:0]   w_rdata_cap;

    assign w_busy       = arb_busy(r_state);
    assign w_burst_full = (r_burst == BURST_W'(D_BURST));
    assign w_pick_inst  = arb_pick_inst(ic_req, dc_req, w_burst_full);

    // Watchdog counts only in-flight cycles that did not see bus_ack, so a
    // bus_ack on the expiry cycle always wins over the timeout
    mem_port_arbiter_bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_bus_watchdog (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (!w_busy),
        .i_enable   (w_busy && !bus_ack),
        .o_expire_c (w_wd_expire_c)
    );

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ARB_IDLE;
            r_burst     <= '0;
            r_bus_cyc   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_ic_ack    <= 1'b0;
            r_dc_ack    <= 1'b0;
            r_ic_data   <= '0;
            r_dc_rdata  <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_burst     <= w_burst_nxt;
            r_bus_cyc   <= w_bus_cyc_nxt;
            r_bus_we    <= w_bus_we_nxt;
            r_bus_addr  <= w_bus_addr_nxt;
            r_bus_wdata <= w_bus_wdata_nxt;
            r_ic_ack    <= w_ic_ack_nxt;
            r_dc_ack    <= w_dc_ack_nxt;
            r_ic_data   <= w_ic_data_nxt;
            r_dc_rdata  <= w_dc_rdata_nxt;
            r_bus_err   <= w_bus_err_nxt;
        end
    end

    // Next-state and output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_burst_nxt     = r_burst;
        w_bus_cyc_nxt   = r_bus_cyc;
        w_bus_we_nxt    = r_bus_we;
        w_bus_addr_nxt  = r_bus_addr;
        w_bus_wdata_nxt = r_bus_wdata;
        w_ic_ack_nxt    = 1'b0;
        w_dc_ack_nxt    = 1'b0;
        w_ic_data_nxt   = r_ic_data;
        w_dc_rdata_nxt  = r_dc_rdata;
        w_bus_err_nxt   = r_bus_err;
        w_rdata_cap     = '0;

        case (r_state)
            ARB_IDLE: begin
                // The burst only counts data grants taken while fetch is waiting
                if (!ic_req) begin
                    w_burst_nxt = '0;
                end
                if (w_pick_inst) begin
                    w_state_nxt    = ARB_INST;
                    w_burst_nxt    = '0;
                    w_bus_cyc_nxt  = 1'b1;
                    w_bus_we_nxt   = 1'b0;
                    w_bus_addr_nxt = ic_addr;
                end else if (dc_req) begin
                    w_state_nxt     = ARB_DATA;
                    if (ic_req) begin
                        w_burst_nxt = r_burst + BURST_W'(1);
                    end
                    w_bus_cyc_nxt   = 1'b1;
                    w_bus_we_nxt    = dc_we;
                    w_bus_addr_nxt  = dc_addr;
                    w_bus_wdata_nxt = dc_wdata;
                end
            end

            ARB_DATA, ARB_INST: begin
                if (bus_ack || w_wd_expire_c) begin
                    // A timed-out transaction completes with zero data
                    w_rdata_cap   = bus_ack ? bus_rdata : '0;
                    w_state_nxt   = ARB_RESP;
                    w_bus_cyc_nxt = 1'b0;
                    w_bus_we_nxt  = 1'b0;
                    if (!bus_ack) begin
                        w_bus_err_nxt = 1'b1;
                    end
                    if (r_state == ARB_INST) begin
                        w_ic_ack_nxt  = 1'b1;
                        w_ic_data_nxt = w_rdata_cap;
                    end else begin
                        w_dc_ack_nxt   = 1'b1;
                        w_dc_rdata_nxt = w_rdata_cap;
                    end
                end
            end

            ARB_RESP: begin
                w_state_nxt = ARB_IDLE;
            end

            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    assign ic_ack    = r_ic_ack;
    assign ic_data   = r_ic_data;
    assign dc_ack    = r_dc_ack;
    assign dc_rdata  = r_dc_rdata;
    assign bus_cyc   = r_bus_cyc;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_err   = r_bus_err;

    // Pipeline must hold while either side is still waiting for its ack
    assign stall = (ic_req & ~r_ic_ack) | (dc_req & ~r_dc_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed and randomized transactions against mem_port_arbiter with a
// transaction-level reference model (grant choice, latency, data, error).
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned D_BURST = 2;

    logic              clk;
    logic              rst;
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic [DATA_W-1:0] ic_data;
    logic              ic_ack;
    logic              dc_req;
    logic              dc_we;
    logic [ADDR_W-1:0] dc_addr;
    logic [DATA_W-1:0] dc_wdata;
    logic [DATA_W-1:0] dc_rdata;
    logic              dc_ack;
    logic              bus_cyc;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;
    logic              stall;
    logic              bus_err;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int   m_burst    = 0;
    logic m_err      = 1'b0;
    logic m_gnt_inst = 1'b0;

    mem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT),
        .D_BURST (D_BURST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ic_req    (ic_req),
        .ic_addr   (ic_addr),
        .ic_data   (ic_data),
        .ic_ack    (ic_ack),
        .dc_req    (dc_req),
        .dc_we     (dc_we),
        .dc_addr   (dc_addr),
        .dc_wdata  (dc_wdata),
        .dc_rdata  (dc_rdata),
        .dc_ack    (dc_ack),
        .bus_cyc   (bus_cyc),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .stall     (stall),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Data is older in program order; fetch gets in after D_BURST data grants
    function automatic logic model_grant();
        logic inst;
        inst = ic_req && (!dc_req || m_burst >= int'(D_BURST));
        if (!ic_req || inst) m_burst = 0;
        else                 m_burst = m_burst + 1;
        return inst;
    endfunction

    // Serve one bus transaction and check it end to end.
    // ack_after: busy cycles before bus_ack (>= TIMEOUT means never).
    task automatic run_txn(input string tag, input int ack_after, input logic [31:0] rd,
                           input int exp_wait, output logic obs_inst);
        logic        g_inst;
        logic [31:0] e_addr;
        logic        e_we;
        logic [31:0] e_wdata;
        logic        e_load;
        logic        timed_out;
        int          e_cyc;
        logic [31:0] e_data;
        logic        stable;
        int          w;
        int          n;

        g_inst     = model_grant();
        m_gnt_inst = g_inst;
        e_addr     = g_inst ? ic_addr : dc_addr;
        e_we       = g_inst ? 1'b0 : dc_we;
        e_wdata    = dc_wdata;
        e_load     = !g_inst && !dc_we;
        timed_out  = (ack_after >= int'(TIMEOUT));
        e_cyc      = timed_out ? int'(TIMEOUT) : ack_after + 1;
        e_data     = timed_out ? 32'h0 : rd;

        tick();
        w = 1;
        chk({tag, "_acks_low"}, {30'b0, ic_ack, dc_ack}, 32'h0);
        while (bus_cyc !== 1'b1 && w < 8) begin
            tick();
            w++;
        end
        chk({tag, "_grant"}, {31'b0, bus_cyc}, 32'h1);
        if (bus_cyc !== 1'b1) begin
            obs_inst = ic_ack;
            return;
        end
        if (exp_wait != 0) chk({tag, "_latency"}, 32'(w), 32'(exp_wait));
        chk({tag, "_addr"}, bus_addr, e_addr);
        chk({tag, "_we"}, {31'b0, bus_we}, {31'b0, e_we});
        if (!g_inst) chk({tag, "_wdata"}, bus_wdata, e_wdata);

        stable = 1'b1;
        n = 0;
        for (int k = 0; k < 300; k++) begin
            n++;
            if (bus_addr !== e_addr || bus_we !== e_we || (!g_inst && bus_wdata !== e_wdata))
                stable = 1'b0;
            if (n - 1 == ack_after) begin
                bus_ack   = 1'b1;
                bus_rdata = rd;
            end
            tick();
            bus_ack   = 1'b0;
            bus_rdata = $urandom();
            if (bus_cyc !== 1'b1) break;
        end
        chk({tag, "_cyc_len"}, 32'(n), 32'(e_cyc));
        chk({tag, "_stable"}, {31'b0, stable}, 32'h1);

        // Now in the response cycle
        m_err    = m_err | timed_out;
        obs_inst = ic_ack;
        chk({tag, "_ic_ack"}, {31'b0, ic_ack}, {31'b0, g_inst});
        chk({tag, "_dc_ack"}, {31'b0, dc_ack}, {31'b0, !g_inst});
        if (g_inst) chk({tag, "_ic_data"}, ic_data, e_data);
        else if (e_load) chk({tag, "_dc_rdata"}, dc_rdata, e_data);
        chk({tag, "_bus_err"}, {31'b0, bus_err}, {31'b0, m_err});
        chk({tag, "_stall"}, {31'b0, stall}, {31'b0, g_inst ? dc_req : ic_req});
    endtask

    logic oi;
    int   r;
    logic exp_order [6];

    initial begin
        rst = 1'b1; ic_req = 1'b0; ic_addr = '0; dc_req = 1'b0; dc_we = 1'b0;
        dc_addr = '0; dc_wdata = '0; bus_rdata = '0; bus_ack = 1'b0;
        exp_order[0] = 1'b0; exp_order[1] = 1'b0; exp_order[2] = 1'b1;
        exp_order[3] = 1'b0; exp_order[4] = 1'b0; exp_order[5] = 1'b1;

        // Reset state
        tick(); tick();
        chk("rst_bus_cyc", {31'b0, bus_cyc}, 32'h0);
        chk("rst_acks", {30'b0, ic_ack, dc_ack}, 32'h0);
        chk("rst_bus_err", {31'b0, bus_err}, 32'h0);
        chk("rst_bus_we", {31'b0, bus_we}, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        rst = 1'b0;

        // Stray bus_ack in IDLE is ignored
        bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
        tick();
        bus_ack = 1'b0;
        tick();
        chk("idle_ack_acks", {30'b0, ic_ack, dc_ack}, 32'h0);
        chk("idle_ack_cyc", {31'b0, bus_cyc}, 32'h0);

        // 1: single fetch on a zero-wait bus
        ic_req = 1'b1; ic_addr = 32'h0000_0040;
        run_txn("t1", 0, 32'h2008_0005, 1, oi);
        ic_req = 1'b0;
        tick();
        chk("t1_ack_one_cycle", {31'b0, ic_ack}, 32'h0);

        // 2: simultaneous requests, store goes first
        ic_req = 1'b1; ic_addr = 32'h0000_0044;
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h0000_0100; dc_wdata = 32'hDEAD_BEEF;
        #1;
        chk("t2_stall_pending", {31'b0, stall}, 32'h1);
        run_txn("t2d", 1, $urandom(), 1, oi);
        chk("t2_first_is_data", {31'b0, oi}, 32'h0);
        dc_req = 1'b0;
        run_txn("t2i", 2, $urandom(), 2, oi);
        chk("t2_second_is_inst", {31'b0, oi}, 32'h1);
        ic_req = 1'b0;
        tick();
        chk("t2_stall_done", {31'b0, stall}, 32'h0);

        // 3: continuous loads with a waiting fetch -> D,D,I,D,D,I
        ic_req = 1'b1; ic_addr = $urandom();
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = $urandom();
        for (int i = 0; i < 6; i++) begin
            run_txn($sformatf("t3_%0d", i), int'($urandom_range(0, 2)), $urandom(),
                    (i == 0) ? 1 : 2, oi);
            chk($sformatf("t3_order_%0d", i), {31'b0, oi}, {31'b0, exp_order[i]});
            if (m_gnt_inst) ic_addr = $urandom();
            else            dc_addr = $urandom();
        end
        ic_req = 1'b0; dc_req = 1'b0;

        // 6: bus_ack on the watchdog expiry cycle returns real data
        tick();
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = $urandom();
        run_txn("t6", int'(TIMEOUT) - 1, $urandom(), 1, oi);
        dc_req = 1'b0;

        // Randomized traffic, bus always answers in time
        for (int it = 0; it < 40; it++) begin
            if (!ic_req && !dc_req) begin
                r = int'($urandom_range(1, 3));
                if (r[0]) begin
                    ic_req = 1'b1; ic_addr = $urandom();
                end
                if (r[1]) begin
                    dc_req = 1'b1; dc_we = 1'($urandom_range(0, 1));
                    dc_addr = $urandom(); dc_wdata = $urandom();
                end
            end
            run_txn($sformatf("rnd%0d", it), int'($urandom_range(0, 3)), $urandom(), 0, oi);
            if (m_gnt_inst) begin
                if ($urandom_range(0, 1) == 1) ic_addr = $urandom();
                else                           ic_req = 1'b0;
            end else begin
                if ($urandom_range(0, 1) == 1) begin
                    dc_we = 1'($urandom_range(0, 1));
                    dc_addr = $urandom(); dc_wdata = $urandom();
                end else begin
                    dc_req = 1'b0;
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (ic_req || dc_req) begin
                run_txn($sformatf("drain%0d", k), 0, $urandom(), 0, oi);
                if (m_gnt_inst) ic_req = 1'b0;
                else            dc_req = 1'b0;
            end
        end

        // 4: bus never answers -> watchdog error, sticky
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = $urandom();
        run_txn("t4", 99, $urandom(), 0, oi);
        dc_req = 1'b0;
        ic_req = 1'b1; ic_addr = $urandom();
        run_txn("t4_after", 0, $urandom(), 0, oi);
        ic_req = 1'b0;
        tick(); tick();
        chk("t4_err_sticky", {31'b0, bus_err}, 32'h1);

        // 5: async reset in the middle of a data transaction
        ic_req = 1'b1; ic_addr = $urandom();
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = $urandom();
        run_txn("t5a", 0, $urandom(), 1, oi);
        dc_addr = $urandom();
        oi = model_grant();
        tick(); tick();
        chk("t5_mid_data", {31'b0, bus_cyc}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_cyc", {31'b0, bus_cyc}, 32'h0);
        chk("t5_async_acks", {30'b0, ic_ack, dc_ack}, 32'h0);
        chk("t5_async_err", {31'b0, bus_err}, 32'h0);
        m_burst = 0;
        m_err   = 1'b0;
        tick(); tick();
        rst = 1'b0;
        run_txn("t5b", 1, $urandom(), 1, oi);
        chk("t5_first_grant_data", {31'b0, oi}, 32'h0);
        dc_req = 1'b0;
        run_txn("t5c", 0, $urandom(), 2, oi);
        ic_req = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
